// File: rtl/sel_mux_seq.sv
// Registered N-channel selector with direct, scanning and hold modes.
// Output beats obey a valid/ready handshake; wrap and sel_err are single-cycle event pulses.
module sel_mux_seq #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] din,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [SW-1:0]     sel,
    input  logic [1:0]        mode,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    output logic              sel_err,
    output logic              wrap
);

    typedef enum logic [1:0] {
        S_DIRECT = 2'd0,
        S_SCAN   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [SW-1:0] ptr;
    logic [7:0]    cnt;

    logic [W-1:0]  nxt_data;
    logic [SW-1:0] nxt_ch;
    logic          nxt_valid;
    logic          nxt_sel_err;
    logic          nxt_wrap;
    logic [SW-1:0] nxt_ptr;
    logic [7:0]    nxt_cnt;

    logic          load;
    logic          sel_ok;
    logic          any_en;
    logic          ptr_en;
    logic [SW-1:0] adv_ptr;

    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus,
                                          input logic [SW-1:0]     idx);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == SW'(i)) r = bus[i*W +: W];
        end
        return r;
    endfunction

    function automatic logic is_enabled(input logic [N_CH-1:0] en,
                                        input logic [SW-1:0]   idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == SW'(i)) r = en[i];
        end
        return r;
    endfunction

    // Lowest enabled index above cur, falling back to the lowest enabled index overall.
    function automatic logic [SW-1:0] next_enabled(input logic [SW-1:0]   cur,
                                                   input logic [N_CH-1:0] en);
        logic [SW-1:0] lowest;
        logic [SW-1:0] above;
        logic          have_above;
        lowest     = '0;
        above      = '0;
        have_above = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en[i]) begin
                lowest = SW'(i);
                if (SW'(i) > cur) begin
                    above      = SW'(i);
                    have_above = 1'b1;
                end
            end
        end
        return have_above ? above : lowest;
    endfunction

    assign load    = !out_valid || out_ready;
    assign sel_ok  = 32'(sel) < 32'(N_CH);
    assign any_en  = |ch_en;
    assign ptr_en  = is_enabled(ch_en, ptr);
    assign adv_ptr = next_enabled(ptr, ch_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_DIRECT;
        end else begin
            state <= next_state;
        end
    end

    // The registered state decides what this edge does; mode only picks the state for the next edge.
    always_comb begin
        next_state  = state;
        nxt_data    = out_data;
        nxt_ch      = out_ch;
        nxt_valid   = out_valid;
        nxt_sel_err = 1'b0;
        nxt_wrap    = 1'b0;
        nxt_ptr     = ptr;
        nxt_cnt     = cnt;

        case (mode)
            2'b00:   next_state = S_DIRECT;
            2'b01:   next_state = S_SCAN;
            default: next_state = S_HOLD;
        endcase

        case (state)
            S_DIRECT: begin
                if (load) begin
                    if (sel_ok) begin
                        nxt_data  = pick(din, sel);
                        nxt_ch    = sel;
                        nxt_valid = 1'b1;
                    end else begin
                        nxt_valid   = 1'b0;
                        nxt_sel_err = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (!any_en) begin
                    if (load) nxt_valid = 1'b0;
                end else if (!ptr_en) begin
                    // A disabled pointer is skipped even under backpressure so it never stalls on a dead channel.
                    nxt_ptr  = adv_ptr;
                    nxt_cnt  = '0;
                    nxt_wrap = (adv_ptr <= ptr);
                end else if (load) begin
                    nxt_data  = pick(din, ptr);
                    nxt_ch    = ptr;
                    nxt_valid = 1'b1;
                    if (cnt == 8'(DWELL - 1)) begin
                        nxt_cnt  = '0;
                        nxt_ptr  = adv_ptr;
                        nxt_wrap = (adv_ptr <= ptr);
                    end else begin
                        nxt_cnt = cnt + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (next_state == S_SCAN && state != S_SCAN) nxt_cnt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            out_data  <= nxt_data;
            out_ch    <= nxt_ch;
            out_valid <= nxt_valid;
            sel_err   <= nxt_sel_err;
            wrap      <= nxt_wrap;
            ptr       <= nxt_ptr;
            cnt       <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_sel_mux_seq.sv
// Bench for sel_mux_seq: a 4-channel DUT checked against a behavioural model,
// plus a 3-channel DUT for out-of-range select and single-channel wrap.
`timescale 1ns/1ps
module tb_sel_mux_seq;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DW  = 2;
    localparam int BN  = 3;
    localparam int BDW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;

    logic [N*W-1:0] din;
    logic [N-1:0]   ch_en;
    logic [1:0]     sel;
    logic [1:0]     mode;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           sel_err;
    logic           wrap;

    logic [BN*W-1:0] b_din;
    logic [BN-1:0]   b_ch_en;
    logic [1:0]      b_sel;
    logic [1:0]      b_mode;
    logic            b_out_ready;
    logic [W-1:0]    b_out_data;
    logic [1:0]      b_out_ch;
    logic            b_out_valid;
    logic            b_sel_err;
    logic            b_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the 4-channel DUT
    int         m_active;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_data;
    logic [1:0] m_ch;
    logic       m_valid;
    logic       m_sel_err;
    logic       m_wrap;

    sel_mux_seq #(.N_CH(N), .W(W), .DWELL(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .ch_en(ch_en), .sel(sel), .mode(mode),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .sel_err(sel_err), .wrap(wrap)
    );

    sel_mux_seq #(.N_CH(BN), .W(W), .DWELL(BDW)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .ch_en(b_ch_en), .sel(b_sel), .mode(b_mode),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_valid(b_out_valid), .sel_err(b_sel_err), .wrap(b_wrap)
    );

    function automatic int scan_next(int p, logic [N-1:0] en);
        for (int k = 1; k <= N; k++) begin
            if (en[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic model_clear();
        m_active  = 0;
        m_ptr     = 0;
        m_cnt     = 0;
        m_data    = '0;
        m_ch      = '0;
        m_valid   = 1'b0;
        m_sel_err = 1'b0;
        m_wrap    = 1'b0;
    endtask

    task automatic model_step();
        bit load;
        int req;
        int np;
        if (rst_n !== 1'b1) begin
            model_clear();
            return;
        end
        load      = !m_valid || out_ready;
        req       = (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : 2;
        m_sel_err = 1'b0;
        m_wrap    = 1'b0;
        if (m_active == 0) begin
            if (load) begin
                if (int'(sel) < N) begin
                    m_data  = din[int'(sel)*W +: W];
                    m_ch    = sel;
                    m_valid = 1'b1;
                end else begin
                    m_valid   = 1'b0;
                    m_sel_err = 1'b1;
                end
            end
        end else if (m_active == 1) begin
            if (ch_en == '0) begin
                if (load) m_valid = 1'b0;
            end else if (!ch_en[m_ptr]) begin
                np     = scan_next(m_ptr, ch_en);
                m_wrap = (np <= m_ptr);
                m_ptr  = np;
                m_cnt  = 0;
            end else if (load) begin
                m_data  = din[m_ptr*W +: W];
                m_ch    = 2'(m_ptr);
                m_valid = 1'b1;
                m_cnt++;
                if (m_cnt == DW) begin
                    m_cnt  = 0;
                    np     = scan_next(m_ptr, ch_en);
                    m_wrap = (np <= m_ptr);
                    m_ptr  = np;
                end
            end
        end
        if (req == 1 && m_active != 1) m_cnt = 0;
        m_active = req;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din = 32'hD3C2B1A0; ch_en = '0; sel = '0; mode = 2'b00; out_ready = 1'b1;
        b_din = {8'h77, 8'h55, 8'h33}; b_ch_en = '0; b_sel = '0; b_mode = 2'b00; b_out_ready = 1'b1;
        model_clear();
        #2;
        n_checks++;
        if ({out_data, out_ch, out_valid, sel_err, wrap} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got %h want 0", {out_data, out_ch, out_valid, sel_err, wrap});
        end
        n_checks++;
        if ({b_out_data, b_out_ch, b_out_valid, b_sel_err, b_wrap} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got %h want 0", {b_out_data, b_out_ch, b_out_valid, b_sel_err, b_wrap});
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        logic [7:0] exp_d [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            n_checks++;
            if (out_data !== exp_d[i] || out_ch !== 2'(i) || out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL direct_sel%0d: got data=%h ch=%0d v=%b want data=%h ch=%0d v=1",
                         i, out_data, out_ch, out_valid, exp_d[i], i);
            end
            n_checks++;
            if ({out_data, out_ch, out_valid, sel_err, wrap} !== {m_data, m_ch, m_valid, m_sel_err, m_wrap}) begin
                n_fail++;
                $display("[TB] FAIL direct_model%0d: got %h want %h", i,
                         {out_data, out_ch, out_valid, sel_err, wrap}, {m_data, m_ch, m_valid, m_sel_err, m_wrap});
            end
        end
    endtask

    task automatic test_sel_error();
        b_sel = 2'd3;
        tick();
        n_checks++;
        if (b_out_valid !== 1'b0 || b_sel_err !== 1'b1 || b_out_data !== 8'h33 || b_out_ch !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL sel_err_raise: got v=%b err=%b data=%h ch=%0d want v=0 err=1 data=33 ch=0",
                     b_out_valid, b_sel_err, b_out_data, b_out_ch);
        end
        b_sel = 2'd1;
        tick();
        n_checks++;
        if (b_out_valid !== 1'b1 || b_sel_err !== 1'b0 || b_out_data !== 8'h55 || b_out_ch !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL sel_err_recover: got v=%b err=%b data=%h ch=%0d want v=1 err=0 data=55 ch=1",
                     b_out_valid, b_sel_err, b_out_data, b_out_ch);
        end
        b_sel = 2'd2;
        tick();
        n_checks++;
        if (b_sel_err !== 1'b0 || b_out_data !== 8'h77) begin
            n_fail++;
            $display("[TB] FAIL sel_last_channel: got err=%b data=%h want err=0 data=77", b_sel_err, b_out_data);
        end
    endtask

    task automatic test_single_channel_wrap();
        logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        logic       exp_wr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        b_ch_en = 3'b010;
        b_mode  = 2'b01;
        b_sel   = 2'd0;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (b_out_ch !== exp_ch[i] || b_wrap !== exp_wr[i] || b_out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL single_wrap%0d: got ch=%0d wrap=%b v=%b want ch=%0d wrap=%b v=1",
                         i, b_out_ch, b_wrap, b_out_valid, exp_ch[i], exp_wr[i]);
            end
        end
        b_mode = 2'b10;
    endtask

    task automatic test_scan_sequence();
        logic [1:0] exp_ch [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
        int wraps;
        wraps = 0;
        ch_en = 4'b1011;
        mode  = 2'b01;
        sel   = 2'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wrap === 1'b1) wraps++;
            n_checks++;
            if (out_ch !== exp_ch[i] || out_data !== din[int'(exp_ch[i])*W +: W] ||
                out_valid !== 1'b1 || wrap !== (i == 5)) begin
                n_fail++;
                $display("[TB] FAIL scan_beat%0d: got ch=%0d data=%h wrap=%b want ch=%0d wrap=%b",
                         i, out_ch, out_data, wrap, exp_ch[i], (i == 5));
            end
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("[TB] FAIL scan_wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_backpressure();
        tick();
        n_checks++;
        if (out_ch !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL stall_setup: got ch=%0d want 1", out_ch);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = $urandom;
            tick();
            n_checks++;
            if (out_ch !== 2'd1 || out_data !== 8'hB1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stall_cycle%0d: got ch=%0d data=%h v=%b want ch=1 data=b1 v=1",
                         i, out_ch, out_data, out_valid);
            end
        end
        din       = 32'hD3C2B1A0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_ch !== 2'd1 || out_data !== 8'hB1) begin
            n_fail++;
            $display("[TB] FAIL stall_resume: got ch=%0d data=%h want ch=1 data=b1", out_ch, out_data);
        end
        tick();
        n_checks++;
        if (out_ch !== 2'd3 || {out_data, out_ch, out_valid, sel_err, wrap} !== {m_data, m_ch, m_valid, m_sel_err, m_wrap}) begin
            n_fail++;
            $display("[TB] FAIL stall_advance: got %h want %h (ch 3)",
                     {out_data, out_ch, out_valid, sel_err, wrap}, {m_data, m_ch, m_valid, m_sel_err, m_wrap});
        end
    endtask

    task automatic test_chen_change();
        ch_en = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL chen_zero: got v=%b want 0", out_valid);
        end
        ch_en = 4'b0100;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || m_ptr != 2) begin
            n_fail++;
            $display("[TB] FAIL chen_skip: got v=%b model_ptr=%0d want v=0 ptr=2", out_valid, m_ptr);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hC2) begin
            n_fail++;
            $display("[TB] FAIL chen_new_channel: got v=%b ch=%0d data=%h want v=1 ch=2 data=c2",
                     out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_hold();
        logic [7:0] hold_data;
        mode = 2'b10;
        tick();
        hold_data = m_data;
        for (int i = 0; i < 6; i++) begin
            din       = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            mode      = (i == 3) ? 2'b11 : 2'b10;
            tick();
            n_checks++;
            if (out_data !== hold_data || sel_err !== 1'b0 || wrap !== 1'b0 ||
                {out_data, out_ch, out_valid, sel_err, wrap} !== {m_data, m_ch, m_valid, m_sel_err, m_wrap}) begin
                n_fail++;
                $display("[TB] FAIL hold%0d: got %h want %h (data %h)", i,
                         {out_data, out_ch, out_valid, sel_err, wrap}, {m_data, m_ch, m_valid, m_sel_err, m_wrap}, hold_data);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r         = $urandom_range(0, 9);
            mode      = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
            sel       = 2'($urandom_range(0, 3));
            ch_en     = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            din       = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            n_checks++;
            if ({out_data, out_ch, out_valid, sel_err, wrap} !== {m_data, m_ch, m_valid, m_sel_err, m_wrap}) begin
                n_fail++;
                $display("[TB] FAIL random%0d: got %h want %h", i,
                         {out_data, out_ch, out_valid, sel_err, wrap}, {m_data, m_ch, m_valid, m_sel_err, m_wrap});
            end
        end
    endtask

    task automatic test_async_reset();
        mode      = 2'b01;
        ch_en     = 4'b0001;
        out_ready = 1'b1;
        din       = 32'hD3C2B1A0;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_pending: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
        end
        #3;
        rst_n = 1'b0;
        #0.5;
        model_clear();
        n_checks++;
        if ({out_data, out_ch, out_valid, sel_err, wrap} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL areset_immediate: got %h want 0", {out_data, out_ch, out_valid, sel_err, wrap});
        end
        #0.5;
        rst_n     = 1'b1;
        sel       = 2'd3;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_ch !== 2'd3 || out_data !== 8'hD3 || out_valid !== 1'b1 ||
            {out_data, out_ch, out_valid, sel_err, wrap} !== {m_data, m_ch, m_valid, m_sel_err, m_wrap}) begin
            n_fail++;
            $display("[TB] FAIL areset_direct: got ch=%0d data=%h v=%b want ch=3 data=d3 v=1",
                     out_ch, out_data, out_valid);
        end
    endtask

    initial begin
        $display("[TB] sel_mux_seq bench starting");
        test_reset();
        test_direct();
        test_sel_error();
        test_single_channel_wrap();
        test_scan_sequence();
        test_backpressure();
        test_chen_change();
        test_hold();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
